// File: rtl/pll_drp_sequencer.sv
// DRP master that holds a PLL in reset, applies a table of read-modify-write
// register updates over the DRP bus, then releases reset and waits for lock.
module pll_drp_sequencer #(
  parameter int TABLE_DEPTH          = 16,
  parameter int RST_HOLD             = 4,
  parameter int DRDY_TIMEOUT         = 64,
  parameter int LOCK_TIMEOUT         = 4096,
  parameter bit WAIT_DRDY_BEFORE_DEN = 1'b1,
  parameter int IDX_W                = $clog2(TABLE_DEPTH)
) (
  input  logic             DCLK,
  input  logic             RST,
  input  logic             SEN,
  input  logic             CFG_WE,
  input  logic [IDX_W-1:0] CFG_IDX,
  input  logic [6:0]       CFG_ADDR,
  input  logic [15:0]      CFG_MASK,
  input  logic [15:0]      CFG_DATA,
  input  logic [IDX_W:0]   CFG_LEN,
  output logic [6:0]       DADDR,
  output logic             DEN,
  output logic             DWE,
  output logic [15:0]      DI,
  input  logic [15:0]      DO,
  input  logic             DRDY,
  output logic             PLL_RST,
  input  logic             LOCKED,
  output logic             BUSY,
  output logic             SRDY,
  output logic             ERR,
  output logic [1:0]       ERR_CODE
);

  localparam int LEN_W = IDX_W + 1;
  localparam int T_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT)
                       ? ((LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD)
                       : ((DRDY_TIMEOUT > RST_HOLD) ? DRDY_TIMEOUT : RST_HOLD);
  localparam int CNT_W = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST_HOLD, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_LOCK_WAIT, S_DONE
  } state_t;

  // Mask bit 1 keeps the value read back from the PLL, 0 takes the table bit.
  function automatic logic [15:0] rmw_merge(input logic [15:0] rd, input logic [15:0] mask,
                                            input logic [15:0] data);
    return (rd & mask) | (data & ~mask);
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(TABLE_DEPTH)) ? LEN_W'(TABLE_DEPTH) : len;
  endfunction

  logic [6:0]  tbl_addr [TABLE_DEPTH];
  logic [15:0] tbl_mask [TABLE_DEPTH];
  logic [15:0] tbl_data [TABLE_DEPTH];

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic [15:0]      rdata_q;
  logic             rdata_ld;

  logic [6:0]  daddr_d;
  logic        den_d, dwe_d, pll_rst_d, busy_d, srdy_d, err_d;
  logic [15:0] di_d;
  logic [1:0]  err_code_d;
  logic        fire, drdy_late, lock_late, drdy_err, lock_err;

  // Table is frozen for the whole sequence so entries cannot change mid-walk.
  always_ff @(posedge DCLK) begin
    if (CFG_WE && !BUSY) begin
      tbl_addr[CFG_IDX] <= CFG_ADDR;
      tbl_mask[CFG_IDX] <= CFG_MASK;
      tbl_data[CFG_IDX] <= CFG_DATA;
    end
  end

  always_ff @(posedge DCLK) begin
    if (rdata_ld) rdata_q <= DO;
  end

  assign fire      = !WAIT_DRDY_BEFORE_DEN || DRDY;
  assign drdy_late = (cnt_q >= CNT_W'(DRDY_TIMEOUT - 1));
  assign lock_late = (cnt_q >= CNT_W'(LOCK_TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    daddr_d    = DADDR;
    den_d      = 1'b0;
    dwe_d      = DWE;
    di_d       = DI;
    pll_rst_d  = PLL_RST;
    busy_d     = BUSY;
    srdy_d     = 1'b0;
    err_d      = ERR;
    err_code_d = ERR_CODE;
    rdata_ld   = 1'b0;
    drdy_err   = 1'b0;
    lock_err   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (SEN) begin
          busy_d     = 1'b1;
          err_d      = 1'b0;
          err_code_d = 2'd0;
          idx_d      = '0;
          cnt_d      = '0;
          len_d      = clamp_len(CFG_LEN);
          if (clamp_len(CFG_LEN) != '0) begin
            pll_rst_d = 1'b1;
            state_d   = S_RST_HOLD;
          end else begin
            srdy_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RST_HOLD: begin
        if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = S_RD_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD_REQ, S_WR_REQ: begin
        if (fire) begin
          den_d   = 1'b1;
          dwe_d   = (state_q == S_WR_REQ);
          daddr_d = tbl_addr[idx_q];
          if (state_q == S_WR_REQ) di_d = rmw_merge(rdata_q, tbl_mask[idx_q], tbl_data[idx_q]);
          first_d = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (state_q == S_WR_REQ) ? S_WR_WAIT : S_RD_WAIT;
        end else if (drdy_late) begin
          drdy_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD_WAIT, S_WR_WAIT: begin
        // DRDY in the DEN cycle is the target's idle level, not a response.
        if (!first_q && DRDY) begin
          cnt_d = '0;
          if (state_q == S_RD_WAIT) begin
            rdata_ld = 1'b1;
            state_d  = S_WR_REQ;
          end else if ({1'b0, idx_q} == len_q - LEN_W'(1)) begin
            pll_rst_d = 1'b0;
            first_d   = 1'b1;
            state_d   = S_LOCK_WAIT;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_RD_REQ;
          end
        end else if (drdy_late) begin
          drdy_err = 1'b1;
        end else begin
          first_d = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_LOCK_WAIT: begin
        if (!first_q && LOCKED) begin
          srdy_d  = 1'b1;
          state_d = S_DONE;
        end else if (lock_late) begin
          lock_err = 1'b1;
        end else begin
          first_d = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (drdy_err || lock_err) begin
      err_d      = 1'b1;
      err_code_d = drdy_err ? 2'd1 : 2'd2;
      pll_rst_d  = 1'b0;
      srdy_d     = 1'b1;
      state_d    = S_DONE;
    end
  end

  always_ff @(posedge DCLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      DADDR    <= '0;
      DEN      <= 1'b0;
      DWE      <= 1'b0;
      DI       <= '0;
      PLL_RST  <= 1'b0;
      BUSY     <= 1'b0;
      SRDY     <= 1'b0;
      ERR      <= 1'b0;
      ERR_CODE <= 2'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      DADDR    <= daddr_d;
      DEN      <= den_d;
      DWE      <= dwe_d;
      DI       <= di_d;
      PLL_RST  <= pll_rst_d;
      BUSY     <= busy_d;
      SRDY     <= srdy_d;
      ERR      <= err_d;
      ERR_CODE <= err_code_d;
    end
  end

endmodule

// File: tb/tb_pll_drp_sequencer.sv
// Randomized bench for pll_drp_sequencer: a DRP target with random response
// latency, a PLL lock model, and a transaction-level reference of the table walk.
module tb_pll_drp_sequencer;
  localparam int DEPTH   = 16;
  localparam int LOCK_TO = 100;

  logic        DCLK = 1'b0;
  logic        RST = 1'b1, SEN = 1'b0, CFG_WE = 1'b0;
  logic [3:0]  CFG_IDX = '0;
  logic [6:0]  CFG_ADDR = '0;
  logic [15:0] CFG_MASK = '0, CFG_DATA = '0;
  logic [4:0]  CFG_LEN = '0;
  logic [6:0]  DADDR;
  logic        DEN, DWE, PLL_RST, BUSY, SRDY, ERR;
  logic [15:0] DI;
  logic [15:0] DO = '0;
  logic        DRDY = 1'b1, LOCKED = 1'b0;
  logic [1:0]  ERR_CODE;

  pll_drp_sequencer #(.TABLE_DEPTH(DEPTH), .LOCK_TIMEOUT(LOCK_TO)) dut (
    .DCLK(DCLK), .RST(RST), .SEN(SEN), .CFG_WE(CFG_WE), .CFG_IDX(CFG_IDX),
    .CFG_ADDR(CFG_ADDR), .CFG_MASK(CFG_MASK), .CFG_DATA(CFG_DATA), .CFG_LEN(CFG_LEN),
    .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI), .DO(DO), .DRDY(DRDY),
    .PLL_RST(PLL_RST), .LOCKED(LOCKED), .BUSY(BUSY), .SRDY(SRDY), .ERR(ERR),
    .ERR_CODE(ERR_CODE)
  );

  always #5 DCLK = ~DCLK;

  typedef struct packed { logic we; logic [6:0] addr; logic [15:0] di; } txn_t;

  int tests_run = 0, tests_failed = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] tgt_mem [128];
  logic [15:0] ref_mem [128];
  logic [6:0]  t_addr [DEPTH];
  logic [15:0] t_mask [DEPTH];
  logic [15:0] t_data [DEPTH];

  // DRP target: idles with DRDY high, answers each access after 0..3 extra cycles.
  bit          drdy_stuck = 1'b0;
  bit          pend = 1'b0;
  int          lat_t = 0;
  logic [15:0] rd_val = '0;
  always @(negedge DCLK) begin
    if (RST) begin
      pend = 1'b0;
      DRDY = 1'b1;
    end else if (DEN) begin
      pend  = 1'b1;
      lat_t = $urandom_range(0, 3);
      if (DWE) begin tgt_mem[DADDR] = DI; rd_val = DI; end
      else rd_val = tgt_mem[DADDR];
    end else if (pend) begin
      if (drdy_stuck) begin DRDY = 1'b0; DO = 16'($urandom); end
      else if (lat_t == 0) begin DRDY = 1'b1; DO = rd_val; pend = 1'b0; end
      else begin DRDY = 1'b0; DO = 16'($urandom); lat_t--; end
    end
  end

  bit lock_never = 1'b0;
  int lock_dly = 5, lk_cnt = 0;
  always @(negedge DCLK) begin
    if (PLL_RST) begin LOCKED = 1'b0; lk_cnt = lock_dly; end
    else if (lock_never) LOCKED = 1'b0;
    else if (lk_cnt == 0) LOCKED = 1'b1;
    else lk_cnt--;
  end

  int cyc = 0;
  always @(posedge DCLK) cyc <= cyc + 1;

  txn_t obs_q[$];
  int   den_bad = 0, pll_hi = 0, den_cyc = 0, fall_cyc = 0;
  logic den_prev = 1'b0, pll_prev = 1'b0;
  always @(negedge DCLK) begin
    if (DEN) begin
      obs_q.push_back({DWE, DADDR, DI});
      den_cyc = cyc;
      if (!PLL_RST || den_prev) den_bad++;
    end
    if (PLL_RST) pll_hi++;
    if (pll_prev && !PLL_RST) fall_cyc = cyc;
    den_prev = DEN;
    pll_prev = PLL_RST;
  end

  task automatic cfg_write(input int i, input logic [6:0] a, input logic [15:0] m,
                           input logic [15:0] d);
    @(negedge DCLK);
    CFG_WE = 1'b1; CFG_IDX = 4'(i); CFG_ADDR = a; CFG_MASK = m; CFG_DATA = d;
    @(negedge DCLK);
    CFG_WE = 1'b0;
    t_addr[i] = a; t_mask[i] = m; t_data[i] = d;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_daddr"}, 32'(DADDR), 0);
    check_val({tag, "_den"}, 32'(DEN), 0);
    check_val({tag, "_dwe"}, 32'(DWE), 0);
    check_val({tag, "_di"}, 32'(DI), 0);
    check_val({tag, "_pll_rst"}, 32'(PLL_RST), 0);
    check_val({tag, "_busy"}, 32'(BUSY), 0);
    check_val({tag, "_srdy"}, 32'(SRDY), 0);
    check_val({tag, "_err"}, 32'(ERR), 0);
    check_val({tag, "_err_code"}, 32'(ERR_CODE), 0);
  endtask

  task automatic start_sen(input int len);
    @(negedge DCLK);
    obs_q.delete(); den_bad = 0; pll_hi = 0;
    lock_dly = $urandom_range(0, 20);
    SEN = 1'b1; CFG_LEN = 5'(len);
    @(negedge DCLK);
    SEN = 1'b0;
  endtask

  task automatic wait_srdy(input int budget, input bit poke, input int poke_idx,
                           output bit got, output int lat);
    lat = 1;
    got = SRDY;
    while (!got && lat < budget) begin
      @(negedge DCLK);
      lat++;
      if (poke && lat == 6) begin
        SEN = 1'b1; CFG_WE = 1'b1; CFG_IDX = 4'(poke_idx);
        CFG_ADDR = 7'h7f; CFG_MASK = 16'h0000; CFG_DATA = 16'hdead;
      end else if (poke && lat == 7) begin
        SEN = 1'b0; CFG_WE = 1'b0;
      end
      got = SRDY;
    end
    SEN = 1'b0; CFG_WE = 1'b0;
  endtask

  // Reference: for each entry, a read of its address then a merged write.
  task automatic run_seq(input string tag, input int len, input bit poke);
    int   eff;
    int   lat;
    bit   got;
    txn_t exp_q[$];
    logic [15:0] v;
    eff = (len > DEPTH) ? DEPTH : len;
    for (int a = 0; a < 128; a++) ref_mem[a] = tgt_mem[a];
    for (int i = 0; i < eff; i++) begin
      exp_q.push_back({1'b0, t_addr[i], 16'h0000});
      v = (ref_mem[t_addr[i]] & t_mask[i]) | (t_data[i] & ~t_mask[i]);
      ref_mem[t_addr[i]] = v;
      exp_q.push_back({1'b1, t_addr[i], v});
    end
    start_sen(len);
    check_val({tag, "_pll_rst_at_sen1"}, 32'(PLL_RST), 32'(eff > 0));
    check_val({tag, "_busy_at_sen1"}, 32'(BUSY), 1);
    check_val({tag, "_err_cleared"}, 32'({ERR, ERR_CODE}), 0);
    wait_srdy(4000, poke, (eff > 0) ? eff - 1 : 0, got, lat);
    check_val({tag, "_srdy_seen"}, 32'(got), 1);
    if (got) begin
      check_val({tag, "_err_at_srdy"}, 32'({ERR, ERR_CODE}), 0);
      check_val({tag, "_busy_at_srdy"}, 32'(BUSY), 1);
      check_val({tag, "_pll_rst_at_srdy"}, 32'(PLL_RST), 0);
      if (eff == 0) check_val({tag, "_len0_latency_le2"}, 32'(lat <= 2), 1);
    end
    @(negedge DCLK);
    check_val({tag, "_busy_after"}, 32'(BUSY), 0);
    check_val({tag, "_srdy_one_cycle"}, 32'(SRDY), 0);
    check_val({tag, "_den_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_val($sformatf("%s_t%0d_we", tag, i), 32'(obs_q[i].we), 32'(exp_q[i].we));
      check_val($sformatf("%s_t%0d_addr", tag, i), 32'(obs_q[i].addr), 32'(exp_q[i].addr));
      if (exp_q[i].we) check_val($sformatf("%s_t%0d_di", tag, i), 32'(obs_q[i].di), 32'(exp_q[i].di));
    end
    check_val({tag, "_den_pulse_rules"}, 32'(den_bad), 0);
    if (eff == 0) check_val({tag, "_no_pll_rst"}, 32'(pll_hi), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int  lat;
    bit  got;
    bit  seen;
    for (int a = 0; a < 128; a++) tgt_mem[a] = 16'($urandom);
    repeat (3) @(negedge DCLK);
    check_outputs_zero("in_reset");
    RST = 1'b0;
    @(negedge DCLK);
    check_outputs_zero("after_reset");

    cfg_write(0, 7'h08, 16'hF000, 16'h0041);
    tgt_mem[8] = 16'h1234;
    run_seq("single", 1, 1'b0);
    if (obs_q.size() > 1) check_val("single_di_1041", 32'(obs_q[1].di), 32'h1041);

    for (int i = 0; i < DEPTH; i++) cfg_write(i, 7'(6 + i), 16'($urandom), 16'($urandom));
    run_seq("full16", 16, 1'b0);
    run_seq("clamp20", 20, 1'b0);

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++)
        cfg_write($urandom_range(0, DEPTH - 1), 7'($urandom), 16'($urandom), 16'($urandom));
      run_seq($sformatf("rand%0d", r), $urandom_range(1, DEPTH), 1'b0);
    end

    run_seq("len0", 0, 1'b0);
    run_seq("busy_poke", 5, 1'b1);
    run_seq("after_poke", 5, 1'b0);

    drdy_stuck = 1'b1;
    start_sen(2);
    wait_srdy(300, 1'b0, 0, got, lat);
    check_val("drdy_to_srdy_seen", 32'(got), 1);
    check_val("drdy_to_single_den", 32'(obs_q.size()), 1);
    if (obs_q.size() > 0) check_val("drdy_to_first_is_read", 32'(obs_q[0].we), 0);
    check_val("drdy_to_err", 32'(ERR), 1);
    check_val("drdy_to_err_code", 32'(ERR_CODE), 1);
    check_val("drdy_to_pll_rst", 32'(PLL_RST), 0);
    check_val("drdy_to_latency_le66", 32'((cyc - den_cyc) <= 66), 1);
    drdy_stuck = 1'b0;
    repeat (10) @(negedge DCLK);

    lock_never = 1'b1;
    start_sen(1);
    wait_srdy(400, 1'b0, 0, got, lat);
    check_val("lock_to_srdy_seen", 32'(got), 1);
    check_val("lock_to_err", 32'(ERR), 1);
    check_val("lock_to_err_code", 32'(ERR_CODE), 2);
    check_val("lock_to_pll_rst", 32'(PLL_RST), 0);
    check_val("lock_to_den_count", 32'(obs_q.size()), 2);
    check_val("lock_to_latency_98_102", 32'(((cyc - fall_cyc) >= 98) && ((cyc - fall_cyc) <= 102)), 1);
    lock_never = 1'b0;
    run_seq("after_lock_to", 1, 1'b0);

    start_sen(3);
    seen = 1'b0;
    for (int n = 0; n < 500 && !seen; n++) begin
      @(negedge DCLK);
      seen = DEN && DWE;
    end
    check_val("rst_reached_wr_wait", 32'(seen), 1);
    #2 RST = 1'b1;
    #1 check_outputs_zero("mid_rst");
    repeat (2) @(negedge DCLK);
    RST = 1'b0;
    @(negedge DCLK);
    check_outputs_zero("mid_rst_release");
    run_seq("after_rst", 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
